// File: rtl/controle_servo_multicanal.sv
// controle_servo_multicanal: N-channel servo PWM with a shared period counter and per-channel slew limiting
module controle_servo_multicanal #(
    parameter int N_CANAIS    = 2,
    parameter int POS_BITS    = 3,
    parameter int PERIODO     = 1_000_000,
    parameter int LARGURA_MIN = 35_000,
    parameter int LARGURA_MAX = 110_000,
    parameter int PASSO_RAMPA = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_CANAIS-1:0]          habilita,
    input  logic [N_CANAIS*POS_BITS-1:0] posicao,
    output logic [N_CANAIS-1:0]          controle,
    output logic [N_CANAIS-1:0]          em_posicao,
    output logic                         fim_periodo
);
    localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int PW = CW + POS_BITS;
    localparam logic [CW-1:0] ULTIMO  = CW'(PERIODO - 1);
    localparam logic [CW-1:0] L_MIN   = CW'(LARGURA_MIN);
    localparam logic [CW-1:0] PASSO   = CW'(PASSO_RAMPA);
    localparam logic [PW-1:0] FAIXA   = PW'(LARGURA_MAX - LARGURA_MIN);
    localparam logic [PW-1:0] COD_MAX = PW'((2 ** POS_BITS) - 1);

    if (!(LARGURA_MIN <= LARGURA_MAX && LARGURA_MAX < PERIODO)) begin : g_param_invalido
        $fatal(1, "controle_servo_multicanal: requires LARGURA_MIN <= LARGURA_MAX < PERIODO");
    end

    logic [CW-1:0] contador, contador_prox;
    logic          fronteira;

    assign fronteira     = contador == ULTIMO;
    assign contador_prox = fronteira ? '0 : contador + 1'b1;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            contador    <= '0;
            fim_periodo <= 1'b0;
        end else begin
            contador    <= contador_prox;
            fim_periodo <= contador_prox == '0;
        end

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        logic [CW-1:0] largura, alvo, alvo_c, rampa, largura_prox, dif_sobe, dif_desce;
        logic [PW-1:0] prod;
        logic          hab_s, hab_prox, pwm;
        assign prod   = PW'(posicao[i*POS_BITS +: POS_BITS]) * FAIXA;
        assign alvo_c = L_MIN + CW'(prod / COD_MAX);
        // Everything seen by the pulse comparator is the post-edge state, so the output stays registered
        always_comb begin
            dif_sobe     = alvo_c - largura;
            dif_desce    = largura - alvo_c;
            rampa        = (PASSO_RAMPA == 0) ? alvo_c :
                           (alvo_c >= largura) ? ((dif_sobe <= PASSO) ? alvo_c : largura + PASSO) :
                           ((dif_desce <= PASSO) ? alvo_c : largura - PASSO);
            largura_prox = fronteira ? rampa : largura;
            hab_prox     = fronteira ? habilita[i] : hab_s;
        end
        always_ff @(posedge clock or posedge reset)
            if (reset) begin
                largura <= L_MIN;
                alvo    <= L_MIN;
                hab_s   <= 1'b0;
                pwm     <= 1'b0;
            end else begin
                if (fronteira) begin
                    largura <= rampa;
                    alvo    <= alvo_c;
                    hab_s   <= habilita[i];
                end
                pwm <= (contador_prox < largura_prox) & hab_prox;
            end
        assign controle[i]   = pwm;
        assign em_posicao[i] = largura == alvo;
    end
endmodule

// File: tb/tb_controle_servo_multicanal.sv
// tb_controle_servo_multicanal: scoreboard bench comparing measured pulse widths per period against a reference model
module tb_controle_servo_multicanal;
    localparam int P = 200, LMIN = 35, LMAX = 110, PB = 3;

    typedef struct packed {
        int              per;
        logic [3:0][31:0] w;
        logic [3:0]      em;
    } esp_t;

    logic       clock = 1'b0, reset = 1'b1;
    logic [1:0] habilita = '0;
    logic [5:0] posicao = '0;
    logic [1:0] ctl0, ctl1, em0, em1;
    logic       fim0, fim1;
    int         testes = 0, falhas = 0;
    esp_t       fila[$];
    esp_t       e_mon;
    int         mw[2][2];
    int         nper, len;
    int         w[4];
    bit         gap[4];
    logic [3:0] em_cur, c_mon;

    always #5 clock = ~clock;

    controle_servo_multicanal #(.N_CANAIS(2), .POS_BITS(PB), .PERIODO(P), .LARGURA_MIN(LMIN),
        .LARGURA_MAX(LMAX), .PASSO_RAMPA(0)) dut0 (.clock(clock), .reset(reset), .habilita(habilita),
        .posicao(posicao), .controle(ctl0), .em_posicao(em0), .fim_periodo(fim0));
    controle_servo_multicanal #(.N_CANAIS(2), .POS_BITS(PB), .PERIODO(P), .LARGURA_MIN(LMIN),
        .LARGURA_MAX(LMAX), .PASSO_RAMPA(5)) dut1 (.clock(clock), .reset(reset), .habilita(habilita),
        .posicao(posicao), .controle(ctl1), .em_posicao(em1), .fim_periodo(fim1));

    task automatic verifica(input string tag, input int obs, input int esp);
        testes++;
        if (obs != esp) begin
            falhas++;
            $display("FAIL %s: obtido %0d esperado %0d", tag, obs, esp);
        end
    endtask

    function automatic int alvo_f(input int code);
        return LMIN + code * (LMAX - LMIN) / ((1 << PB) - 1);
    endfunction

    // Measures each period: widths, contiguity from contador==0, period length, em_posicao
    always @(negedge clock) begin
        if (reset) begin
            nper = 0;
            len = 0;
            for (int k = 0; k < 4; k++) begin w[k] = 0; gap[k] = 0; end
            em_cur = {em1, em0};
        end else begin
            if (fim0) begin
                verifica("fim_sinc", int'(fim1), 1);
                if (nper > 0) verifica("periodo_len", len, P);
                if (fila.size() > 0 && fila[0].per == nper) begin
                    e_mon = fila.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        verifica($sformatf("largura_p%0d_d%0dc%0d", nper, k / 2, k % 2), w[k], int'(e_mon.w[k]));
                        verifica($sformatf("contiguo_p%0d_d%0dc%0d", nper, k / 2, k % 2), int'(gap[k]), 0);
                    end
                    verifica($sformatf("em_posicao_p%0d", nper), int'(em_cur), int'(e_mon.em));
                end
                nper++;
                len = 0;
                for (int k = 0; k < 4; k++) begin w[k] = 0; gap[k] = 0; end
                em_cur = {em1, em0};
            end
            c_mon = {ctl1, ctl0};
            for (int k = 0; k < 4; k++)
                if (c_mon[k]) begin
                    if (w[k] != len) gap[k] = 1;
                    w[k]++;
                end
            len++;
        end
    end

    task automatic inicia();
        esp_t e;
        for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) mw[d][c] = LMIN;
        fila.delete();
        e.per = 0;
        e.w = '0;
        e.em = 4'hF;
        fila.push_back(e);
    endtask

    // Drives inputs and steps the reference model for the boundary that opens period per
    task automatic amostra(input logic [1:0] h, input logic [5:0] p, input int per);
        esp_t e;
        int a, dif, ps;
        habilita = h;
        posicao = p;
        e.per = per;
        for (int c = 0; c < 2; c++) begin
            a = alvo_f(int'(p[c*3 +: 3]));
            for (int d = 0; d < 2; d++) begin
                ps = (d == 1) ? 5 : 0;
                dif = a - mw[d][c];
                if (ps == 0 || (dif <= ps && dif >= -ps)) mw[d][c] = a;
                else mw[d][c] += (dif > 0) ? ps : -ps;
                e.w[d*2+c] = h[c] ? mw[d][c] : 0;
                e.em[d*2+c] = mw[d][c] == a;
            end
        end
        fila.push_back(e);
    endtask

    task automatic espera_fim();
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clock);
            if (fim0) return;
        end
        verifica("timeout_fim", 0, 1);
    endtask

    task automatic passo(input logic [1:0] h, input logic [5:0] p);
        espera_fim();
        repeat (20) @(negedge clock);
        amostra(h, p, nper + 1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        verifica("reset_controle", int'({ctl1, ctl0}), 0);
        verifica("reset_em_posicao", int'({em1, em0}), 15);
        verifica("reset_fim", int'({fim1, fim0}), 0);
        reset = 1'b0;
        inicia();
        amostra(2'b11, 6'o00, 1);
        passo(2'b11, 6'o00);
        for (int r = 0; r < 16; r++) passo(2'b11, 6'o07);
        passo(2'b11, 6'o41);
        passo(2'b11, 6'o41);
        passo(2'b11, 6'o47);
        passo(2'b01, 6'o47);
        passo(2'b01, 6'o47);
        passo(2'b11, 6'o47);
        passo(2'b11, 6'o47);
        espera_fim();
        repeat (10) @(negedge clock);
        verifica("controle_antes_reset", int'({ctl1, ctl0}), 15);
        #1 reset = 1'b1;
        #1 verifica("controle_reset_assinc", int'({ctl1, ctl0}), 0);
        repeat (2) @(negedge clock);
        verifica("em_posicao_reset", int'({em1, em0}), 15);
        verifica("fim_reset", int'({fim1, fim0}), 0);
        reset = 1'b0;
        inicia();
        amostra(2'b11, 6'o00, 1);
        passo(2'b11, 6'o20);
        espera_fim();
        espera_fim();
        @(negedge clock);
        #1 verifica("fila_vazia", fila.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

    initial begin
        #500000;
        verifica("watchdog", 0, 1);
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end
endmodule
